// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes, oversampling
// constant and line-control helper functions.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    // Indexed by {sticky_parity, eps}; identical map to the transmitter.
    typedef enum logic [1:0] {
        PAR_ODD   = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } parity_mode_t;

    function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
        return 4'd5 + {2'b00, wls};
    endfunction

    function automatic logic parity_expected(input parity_mode_t mode, input logic x);
        logic p;
        p = 1'b0;
        case (mode)
            PAR_ODD:   p = ~x;
            PAR_EVEN:  p = x;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Generic multi-flop synchroniser for an asynchronous level input; flops reset
// to 1 so an idle-high line reads idle straight out of reset.
module uart_rx_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_top.sv
// 16x-oversampled UART receiver producing one character per frame with parity,
// framing and break status. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MID_SAMPLE  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    output logic       push,
    output logic [7:0] rx_data,
    output logic       pe,
    output logic       fe,
    output logic       bi
);

    localparam logic [3:0] MID_CNT  = 4'(MID_SAMPLE);
    localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);

    logic rx_s;
    logic bit_val;

    rx_state_t    state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [2:0]   bitcnt_q, bitcnt_d;
    logic [7:0]   shift_q, shift_d;
    logic [1:0]   wls_q, wls_d;
    logic         pen_q, pen_d;
    parity_mode_t pmode_q, pmode_d;
    logic         par_bit_q, par_bit_d;
    logic         pe_pend_q, pe_pend_d;
    logic         push_q, push_d;
    logic [7:0]   rx_data_q, rx_data_d;
    logic         pe_q, pe_d;
    logic         fe_q, fe_d;
    logic         bi_q, bi_d;
    logic [2:0]   last_bit;
    logic         brk;

    uart_rx_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two previous samples shift on every baud_pulse; the vote completes on the
    // decision pulse using the live sample as the third.
    logic [1:0] vote_q, vote_d;

    always_comb begin
        vote_d = vote_q;
        if (baud_pulse) begin
            vote_d = {vote_q[0], rx_s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q <= '1;
        end else begin
            vote_q <= vote_d;
        end
    end

    assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign last_bit = 3'(wls_to_bits(wls_q) - 4'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        wls_d     = wls_q;
        pen_d     = pen_q;
        pmode_d   = pmode_q;
        par_bit_d = par_bit_q;
        pe_pend_d = pe_pend_q;
        push_d    = 1'b0;
        rx_data_d = rx_data_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        bi_d      = bi_q;
        brk       = 1'b0;

        if (baud_pulse) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == MID_CNT) begin
                        if (!bit_val) begin
                            wls_d     = wls;
                            pen_d     = pen;
                            pmode_d   = parity_mode_t'({sticky_parity, eps});
                            cnt_d     = '0;
                            bitcnt_d  = '0;
                            shift_d   = '0;
                            par_bit_d = 1'b0;
                            pe_pend_d = 1'b0;
                            state_d   = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_d[bitcnt_q] = bit_val;
                        cnt_d = '0;
                        if (bitcnt_q == last_bit) begin
                            bitcnt_d = '0;
                            state_d  = pen_q ? PARITY : STOP;
                        end else begin
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        par_bit_d = bit_val;
                        pe_pend_d = bit_val != parity_expected(pmode_q, ^shift_q);
                        cnt_d     = '0;
                        state_d   = STOP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        // Upper unused bits of shift_q are cleared at start, so a
                        // whole-byte zero test covers any word length.
                        brk       = (shift_q == 8'h00) && !(pen_q && par_bit_q) && !bit_val;
                        push_d    = 1'b1;
                        rx_data_d = brk ? 8'h00 : shift_q;
                        pe_d      = pen_q & pe_pend_q;
                        fe_d      = ~bit_val;
                        bi_d      = brk;
                        cnt_d     = '0;
                        state_d   = brk ? BRK_WAIT : IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                BRK_WAIT: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            wls_q     <= '0;
            pen_q     <= 1'b0;
            pmode_q   <= PAR_ODD;
            par_bit_q <= 1'b0;
            pe_pend_q <= 1'b0;
            push_q    <= 1'b0;
            rx_data_q <= '0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            wls_q     <= wls_d;
            pen_q     <= pen_d;
            pmode_q   <= pmode_d;
            par_bit_q <= par_bit_d;
            pe_pend_q <= pe_pend_d;
            push_q    <= push_d;
            rx_data_q <= rx_data_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            bi_q      <= bi_d;
        end
    end

    assign push    = push_q;
    assign rx_data = rx_data_q;
    assign pe      = pe_q;
    assign fe      = fe_q;
    assign bi      = bi_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Scoreboard bench for uart_rx_top: frames are serialised on rx, expected
// characters are queued on send and compared on each push.
module tb_uart_rx_top;

    localparam int unsigned BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_pulse = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] wls = 2'b11;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sticky_parity = 1'b0;
    logic       push;
    logic [7:0] rx_data;
    logic       pe;
    logic       fe;
    logic       bi;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bi;
    } exp_t;

    exp_t exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_push = 0;
    int unsigned n_sent = 0;

    uart_rx_top #(
        .SYNC_STAGES(2),
        .MID_SAMPLE (7)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_pulse   (baud_pulse),
        .rx           (rx),
        .wls          (wls),
        .pen          (pen),
        .eps          (eps),
        .sticky_parity(sticky_parity),
        .push         (push),
        .rx_data      (rx_data),
        .pe           (pe),
        .fe           (fe),
        .bi           (bi)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            baud_pulse = 1'b1;
            @(negedge clk);
            baud_pulse = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && push) begin
            n_push++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_push", 32'(push), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("rx_data", 32'(rx_data), 32'(e.data));
                check_eq("pe", 32'(pe), 32'(e.pe));
                check_eq("fe", 32'(fe), 32'(e.fe));
                check_eq("bi", 32'(bi), 32'(e.bi));
            end
        end
    end

    task automatic drive_bit(input logic b, input int unsigned clks);
        rx = b;
        repeat (clks) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    // Builds the expected character independently, then serialises the frame.
    // A zero stop bit is shortened so the line is back high before the
    // receiver could validate a new start bit.
    task automatic send_frame(input logic [7:0] data, input logic [1:0] w, input logic p,
                              input logic e, input logic s, input logic bad_par,
                              input logic stop_bit);
        int unsigned nbits;
        logic [7:0] mask;
        logic [7:0] dm;
        logic x;
        logic par_exp;
        logic par_bit;
        exp_t ex;
        nbits = 5 + int'(w);
        mask  = 8'hFF >> (8 - nbits);
        dm    = data & mask;
        x     = ^dm;
        case ({s, e})
            2'b00:   par_exp = ~x;
            2'b01:   par_exp = x;
            2'b10:   par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
        par_bit = bad_par ? ~par_exp : par_exp;
        ex.bi   = (dm == 8'h00) && !(p && par_bit) && !stop_bit;
        ex.data = ex.bi ? 8'h00 : dm;
        ex.pe   = p && (par_bit != par_exp);
        ex.fe   = !stop_bit;
        wls = w;
        pen = p;
        eps = e;
        sticky_parity = s;
        exp_q.push_back(ex);
        n_sent++;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < int'(nbits); i++) begin
            drive_bit(data[i], BIT_CLKS);
        end
        if (p) begin
            drive_bit(par_bit, BIT_CLKS);
        end
        drive_bit(stop_bit, stop_bit ? BIT_CLKS : 44);
        drive_bit(1'b1, 2 * BIT_CLKS);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t brk;
        int unsigned push_before;

        repeat (3) @(negedge clk);
        check_eq("rst_push", 32'(push), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        check_eq("rst_flags", 32'({pe, fe, bi}), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("drain_a5");

        send_frame(8'h15, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain("drain_par_ok");
        send_frame(8'h15, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_drain("drain_par_bad");

        // Upper bits above the word length must read back as zero.
        send_frame(8'hD5, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain("drain_mark");

        push_before = n_push;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 4 * BIT_CLKS);
        check_eq("glitch_no_push", n_push, push_before);
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("drain_after_glitch");

        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_drain("drain_fe");

        wls = 2'b11;
        pen = 1'b0;
        brk.data = 8'h00;
        brk.pe   = 1'b0;
        brk.fe   = 1'b1;
        brk.bi   = 1'b1;
        exp_q.push_back(brk);
        n_sent++;
        push_before = n_push;
        drive_bit(1'b0, 3 * 10 * BIT_CLKS);
        check_eq("break_one_push", n_push, push_before + 1);
        drive_bit(1'b1, 2 * BIT_CLKS);
        wait_drain("drain_break");
        send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("drain_81");

        push_before = n_push;
        wls = 2'b11;
        pen = 1'b0;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            drive_bit(1'b1, BIT_CLKS);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("midrst_push", 32'(push), 32'd0);
        check_eq("midrst_rx_data", 32'(rx_data), 32'd0);
        check_eq("midrst_flags", 32'({pe, fe, bi}), 32'd0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge clk);
        check_eq("midrst_no_push", n_push, push_before);
        send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("drain_5a");

        repeat (4 * BIT_CLKS) @(negedge clk);
        check_eq("push_count", n_push, n_sent);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
Serial receiver that sits directly downstream of the UART transmit stage: it consumes the `tx` line (or the external RX pin) and produces parallel characters for the RX FIFO.
- Uses the same 16x `baud_pulse` oversampling enable as the transmitter.
- Supports the same line-control settings: `wls`, `pen`, `eps`, `sticky_parity`.
- Per-character parity, framing and break status are pushed alongside the data for use by the LSR.

Parameters:
SYNC_STAGES, 2, number of flops in the `rx` input synchroniser (min 2).
MID_SAMPLE, 7, `baud_pulse` count after the falling edge at which the start bit is validated (mid-bit for 16x oversampling).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
baud_pulse  input  1  one-clk enable at 16x baud rate
rx  input  1  serial line, idle high, asynchronous to clk
wls  input  2  word length select: 00=5, 01=6, 10=7, 11=8 data bits
pen  input  1  parity enable
eps  input  1  even parity select
sticky_parity  input  1  stick parity
push  output  1  one-clk pulse: character valid, write RX FIFO
rx_data  output  8  received character, LSB first on line, unused upper bits 0
pe  output  1  parity error for the pushed character
fe  output  1  framing error (stop bit sampled 0)
bi  output  1  break indication

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, bit counter and oversample counter cleared.
  - Synchroniser flops set to 1.
  - push=0, rx_data=0, pe=0, fe=0, bi=0.
  - A reset mid-frame aborts the frame with no push.
- Sampling and timing:
  - `rx` passes through a SYNC_STAGES synchroniser; the synchronised signal is rx_s.
  - The FSM advances only on clk cycles where baud_pulse=1.
  - A 4-bit oversample counter cnt counts 0..15 and wraps.
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: on baud_pulse with rx_s=0, go to START with cnt=0.
- START: cnt increments each baud_pulse. At cnt==MID_SAMPLE:
  - rx_s=0: valid start bit. Latch wls, pen, eps and sticky_parity into frame registers; cnt=0; bitcnt=0; go to DATA. Configuration changes after this point do not affect the frame in flight.
  - rx_s=1: false start (glitch). Return to IDLE, no push.
- DATA: sample rx_s when cnt==15, then reset cnt=0.
  - Store the sample at rx_data bit position bitcnt (LSB first).
  - After 5+wls bits, go to PARITY if pen=1, else to STOP.
- PARITY:
  - Sample at cnt==15.
  - Expected value, with X = XOR of the received data bits for the latched word length:
    - {sticky,eps}=00 → ~X (odd)
    - 01 → X (even)
    - 10 → 1
    - 11 → 0
  - pe = (sample != expected).
- STOP:
  - Sample at cnt==15.
  - fe = (sample==0).
  - bi = 1 when all data bits, the parity bit (if enabled) and the stop bit are all 0; bi forces rx_data=0.
  - Assert push for exactly one clk with rx_data/pe/fe/bi updated the same cycle.
  - Next state is BRK_WAIT if bi=1, else IDLE.
  - Only the first stop bit is checked; the transmitter's stb setting does not matter.
- BRK_WAIT: stay until rx_s=1 on a baud_pulse, then go to IDLE. There is no push while waiting, so one break produces exactly one character.
- Outputs: rx_data, pe, fe and bi hold their values until the next push.
- Latency: push occurs on the baud_pulse at stop-bit mid-point plus one clk of register delay, plus SYNC_STAGES clks of synchroniser delay.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: every sample decision (start validation, data, parity, stop) uses a 2-of-3 majority of rx_s captured on three consecutive baud_pulses.
  - Start bit: votes at cnt MID_SAMPLE-2, MID_SAMPLE-1 and MID_SAMPLE.
  - Other bits: votes at cnt 13, 14 and 15.
  - The decision is taken on the last vote.
- Undefined: single sample at the decision point, as above.
- Timing of push is identical in both builds.

Decomposition:
- uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT).
  - Parity mode encodings shared with the transmitter ({sticky,eps} map).
  - OVERSAMPLE=16 constant.
  - wls-to-bit-count function.
- Sub-module uart_rx_sync: parameterised SYNC_STAGES flop chain with reset value 1, reusable for other async inputs.

Test Plan:
- wls=11, pen=0, serial frame 0xA5 with 1 stop bit, baud_pulse every 4 clk → exactly one push, rx_data=0xA5, pe=fe=bi=0.
- wls=00, pen=1, eps=1, sticky=0, data 0x15:
  - Parity bit 1 → rx_data=0x15, pe=0.
  - Repeat with parity bit 0 → pe=1.
- rx low for 4 baud_pulses, then high (glitch) → no push, FSM back in IDLE; a following valid 0x3C frame is received correctly.
- wls=11, data 0x3C, stop bit driven 0 → push with rx_data=0x3C, fe=1, bi=0.
- rx held low for 3 character times, then high → exactly one push with rx_data=0x00, bi=1, fe=1; the next frame 0x81 is received normally.
- rst_n pulsed low mid-DATA of a 0xFF frame → all outputs 0, no push; the next 0x5A frame is received correctly.
